jt5205_fetch_ctrl: RTL

- Sequencer that plays an ADPCM clip from ROM into the MSM5205 core.
- CPU programs start/end pages and a play bit. The block fetches bytes over a ROM request/ack handshake and buffers one byte ahead.
- Presents one 4-bit sample to the decoder `din` on every decoder `irq` strobe, holds the decoder in reset while idle, and stops at the end address.
- Sits between the sound CPU bus, the SDRAM/ROM arbiter and the 5205 core.

---
 rtl/jt5205_fetch_ctrl_pkg.sv | 13 +
 rtl/jt5205_fetch_buf.sv | 60 ++++++
 rtl/jt5205_fetch_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/jt5205_fetch_ctrl_pkg.sv
// Shared constants for the 5205 ADPCM fetch sequencer: register select codes
// and the fetch FSM state encoding.
package jt5205_fetch_ctrl_pkg;

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_END   = 2'd1;
  localparam logic [1:0] SEL_CTRL  = 2'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/jt5205_fetch_buf.sv
// One-byte look-ahead buffer feeding the 5205 decoder one nibble per irq.
// Flags an underrun when a sample is due and no byte is waiting.
module jt5205_fetch_buf #(
  parameter int HI_FIRST = 1
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       sample,
  output logic [3:0] din,
  output logic       underrun,
  output logic       take,
  output logic       give
);

  logic [7:0] nxt;
  logic       nxt_v;
  logic       phase;
  logic [3:0] hold;

  // take: first nibble of a buffered byte is consumed; give: held nibble goes out
  assign take = sample & ~phase & nxt_v;
  assign give = sample & phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt      <= '0;
      nxt_v    <= 1'b0;
      phase    <= 1'b0;
      hold     <= '0;
      din      <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (clr) begin
        nxt_v <= 1'b0;
        phase <= 1'b0;
      end else begin
        if (load) begin
          nxt   <= load_data;
          nxt_v <= 1'b1;
        end
        if (give) begin
          din   <= hold;
          phase <= 1'b0;
        end else if (take) begin
          din   <= (HI_FIRST != 0) ? nxt[7:4] : nxt[3:0];
          hold  <= (HI_FIRST != 0) ? nxt[3:0] : nxt[7:4];
          nxt_v <= 1'b0;
          phase <= 1'b1;
        end else if (sample) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jt5205_fetch_ctrl.sv
// ADPCM clip sequencer: fetches ROM bytes between CPU-programmed start/end
// pages and streams them as nibbles into the MSM5205 core.
module jt5205_fetch_ctrl
  import jt5205_fetch_ctrl_pkg::*;
#(
  parameter int AW       = 16,
  parameter int HI_FIRST = 1
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          wr,
  input  logic [1:0]    wr_sel,
  input  logic [7:0]    wr_data,
  input  logic          irq,
  output logic [3:0]    din,
  output logic          adpcm_rst,
  output logic          busy,
  output logic          underrun,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok
);

  logic [1:0]    st;
  logic [7:0]    start_reg;
  logic [7:0]    end_reg;
  logic [7:0]    end_lat;
  logic          first;
  logic          last;
  logic          ctrl_wr;
  logic          sample;
  logic          load;
  logic          take;
  logic          give;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;

  assign ctrl_wr    = wr && (wr_sel == SEL_CTRL);
  // a control write in the same clk masks irq and rom_ok entirely
  assign sample     = irq && (st != ST_IDLE) && !ctrl_wr;
  assign load       = rom_cs && rom_ok && !ctrl_wr;
  assign start_addr = {start_reg, {(AW-8){1'b0}}};
  assign end_addr   = {end_lat, {(AW-8){1'b1}}};

  jt5205_fetch_buf #(
    .HI_FIRST (HI_FIRST)
  ) u_buf (
    .rst       (rst),
    .clk       (clk),
    .clr       (ctrl_wr),
    .load      (load),
    .load_data (rom_data),
    .sample    (sample),
    .din       (din),
    .underrun  (underrun),
    .take      (take),
    .give      (give)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      start_reg <= '0;
      end_reg   <= '0;
      end_lat   <= '0;
      first     <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      adpcm_rst <= 1'b1;
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
    end else begin
      if (wr && wr_sel == SEL_START) start_reg <= wr_data;
      if (wr && wr_sel == SEL_END)   end_reg   <= wr_data;
      if (ctrl_wr) begin
        adpcm_rst <= 1'b1;
        last      <= 1'b0;
        if (wr_data[0]) begin
          st       <= ST_FETCH;
          rom_cs   <= 1'b1;
          rom_addr <= start_addr;
          busy     <= 1'b1;
          end_lat  <= end_reg;
          first    <= 1'b1;
        end else begin
          st     <= ST_IDLE;
          rom_cs <= 1'b0;
          busy   <= 1'b0;
          first  <= 1'b0;
        end
      end else begin
        if (load) begin
          rom_cs <= 1'b0;
          st     <= ST_RUN;
          if (first) begin
            adpcm_rst <= 1'b0;
            first     <= 1'b0;
          end
        end
        // prefetch the next byte as soon as the buffered one is consumed
        if (take) begin
          if (rom_addr != end_addr) begin
            rom_addr <= rom_addr + AW'(1);
            rom_cs   <= 1'b1;
            st       <= ST_FETCH;
          end else begin
            last <= 1'b1;
          end
        end
        if (give && last) begin
          busy      <= 1'b0;
          adpcm_rst <= 1'b1;
          rom_cs    <= 1'b0;
          last      <= 1'b0;
          st        <= ST_IDLE;
        end
      end
    end
  end

endmodule
